vx_reg_wnd_mgr: RTL and testbench

Per-warp register-window manager for the issue/decode path. It remaps architectural source and destination register indices onto a circular physical window file. Call/return instructions push and pop windows. When the physical ring is full or empty, the block sequences spill/fill requests to the memory side. It sits between decode and the register-file read stage, one instance per core.

---
 rtl/vx_wnd_pkg.sv | 33 +++
 rtl/vx_wnd_remap.sv | 25 ++
 rtl/vx_reg_wnd_mgr.sv | 178 +++++++++++++++++
 tb/tb_vx_reg_wnd_mgr.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_wnd_pkg.sv
// Shared constants and types for the per-warp register-window manager.
package vx_wnd_pkg;

    localparam int NUM_WARPS   = 4;
    localparam int WID_W       = $clog2(NUM_WARPS);
    localparam int GLOBAL_REGS = 16;
    localparam int WND_SIZE    = 8;
    localparam int NUM_WND     = 4;
    localparam int MAX_SPILL   = 15;

    localparam int ARCH_REGS   = GLOBAL_REGS + 2 * WND_SIZE;
    localparam int AW          = $clog2(ARCH_REGS);
    localparam int PW          = $clog2(GLOBAL_REGS + NUM_WND * WND_SIZE);
    localparam int RING        = NUM_WND * WND_SIZE;
    localparam int BW          = $clog2(NUM_WND);
    localparam int RW          = $clog2(NUM_WND);
    localparam int SW          = $clog2(MAX_SPILL + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } wnd_state_e;

    typedef struct packed {
        logic [BW-1:0] cwp;
        logic [RW-1:0] res;
        logic [SW-1:0] spl;
    } warp_st_t;

    localparam warp_st_t WARP_RST = '{cwp: '0, res: RW'(1), spl: '0};

endpackage

// File: rtl/vx_wnd_remap.sv
// Combinational mapper from one architectural register index to its physical slot.
// Globals and disabled warps pass straight through; windowed indices rotate around the ring by cwp.
module vx_wnd_remap
    import vx_wnd_pkg::*;
(
    input  logic [AW-1:0] r,
    input  logic [BW-1:0] cwp,
    input  logic          en,
    output logic [PW-1:0] phys
);

    logic [PW-1:0] r_ext;
    logic [PW-1:0] lin;

    always_comb begin
        r_ext = PW'(r);
        lin   = PW'(cwp) * PW'(WND_SIZE) + (r_ext - PW'(GLOBAL_REGS));
        if (en && (r >= AW'(GLOBAL_REGS))) begin
            phys = PW'(GLOBAL_REGS) + (lin % PW'(RING));
        end else begin
            phys = r_ext;
        end
    end

endmodule

// File: rtl/vx_reg_wnd_mgr.sv
// Per-warp register-window manager: remaps decode operands, tracks call/return, sequences spill/fill.
// Remap latency 1 cycle; dec_ready drops while a spill/fill is outstanding, output has no backpressure.
module vx_reg_wnd_mgr
    import vx_wnd_pkg::*;
(
    input  logic                 clk,
    input  logic                 nRST,
    input  logic [NUM_WARPS-1:0] wnd_en,
    input  logic                 dec_valid,
    output logic                 dec_ready,
    input  logic [WID_W-1:0]     dec_wid,
    input  logic [AW-1:0]        dec_rs1,
    input  logic [AW-1:0]        dec_rs2,
    input  logic [AW-1:0]        dec_rs3,
    input  logic [AW-1:0]        dec_rd,
    input  logic                 dec_call,
    input  logic                 dec_ret,
    output logic                 out_valid,
    output logic [WID_W-1:0]     out_wid,
    output logic [PW-1:0]        out_rs1,
    output logic [PW-1:0]        out_rs2,
    output logic [PW-1:0]        out_rs3,
    output logic [PW-1:0]        out_rd,
    output logic                 wnd_err,
    output logic                 spill_valid,
    input  logic                 spill_ready,
    output logic [WID_W-1:0]     spill_wid,
    output logic [BW-1:0]        spill_blk,
    output logic                 spill_fill,
    input  logic                 spill_done
);

    wnd_state_e       state_q, state_d;
    warp_st_t         ws_q [NUM_WARPS];
    warp_st_t         ws_d [NUM_WARPS];
    logic [WID_W-1:0] xfer_wid_q, xfer_wid_d;
    logic [BW-1:0]    xfer_blk_q, xfer_blk_d;
    logic             xfer_fill_q, xfer_fill_d;
    logic             out_valid_q, out_valid_d;
    logic [WID_W-1:0] out_wid_q, out_wid_d;
    logic [PW-1:0]    out_rs1_q, out_rs1_d, out_rs2_q, out_rs2_d;
    logic [PW-1:0]    out_rs3_q, out_rs3_d, out_rd_q, out_rd_d;
    logic             wnd_err_q, wnd_err_d;

    warp_st_t         cur;
    logic             en_cur, is_call, is_ret, ring_full, ring_empty, spl_max, spl_zero;
    logic             need_spill, need_fill, call_err, ret_err, needs_xfer;
    logic [PW-1:0]    p_rs1, p_rs2, p_rs3, p_rd;

    always_comb begin
        cur        = ws_q[dec_wid];
        en_cur     = wnd_en[dec_wid];
        is_call    = en_cur && dec_call && !dec_ret;
        is_ret     = en_cur && dec_ret && !dec_call;
        ring_full  = (cur.res == RW'(NUM_WND - 1));
        ring_empty = (cur.res == RW'(1));
        spl_max    = (cur.spl == SW'(MAX_SPILL));
        spl_zero   = (cur.spl == '0);
        need_spill = is_call && ring_full && !spl_max;
        need_fill  = is_ret && ring_empty && !spl_zero;
        call_err   = is_call && ring_full && spl_max;
        ret_err    = is_ret && ring_empty && spl_zero;
        needs_xfer = need_spill || need_fill;
    end

    // Operands always map through the pre-update cwp of the requesting warp.
    vx_wnd_remap u_map_rs1 (.r(dec_rs1), .cwp(cur.cwp), .en(en_cur), .phys(p_rs1));
    vx_wnd_remap u_map_rs2 (.r(dec_rs2), .cwp(cur.cwp), .en(en_cur), .phys(p_rs2));
    vx_wnd_remap u_map_rs3 (.r(dec_rs3), .cwp(cur.cwp), .en(en_cur), .phys(p_rs3));
    vx_wnd_remap u_map_rd  (.r(dec_rd),  .cwp(cur.cwp), .en(en_cur), .phys(p_rd));

    always_comb begin
        state_d     = state_q;
        ws_d        = ws_q;
        xfer_wid_d  = xfer_wid_q;
        xfer_blk_d  = xfer_blk_q;
        xfer_fill_d = xfer_fill_q;
        out_valid_d = 1'b0;
        out_wid_d   = out_wid_q;
        out_rs1_d   = out_rs1_q;
        out_rs2_d   = out_rs2_q;
        out_rs3_d   = out_rs3_q;
        out_rd_d    = out_rd_q;
        wnd_err_d   = 1'b0;
        dec_ready   = 1'b0;
        spill_valid = 1'b0;
        case (state_q)
            IDLE: begin
                dec_ready = !(dec_valid && needs_xfer);
                if (dec_valid && needs_xfer) begin
                    // Spill the block the callee would overwrite; fill the caller's block back in.
                    xfer_wid_d  = dec_wid;
                    xfer_blk_d  = need_spill ? cur.cwp + BW'(2) : cur.cwp - BW'(1);
                    xfer_fill_d = need_fill;
                    state_d     = REQ;
                end else if (dec_valid) begin
                    out_valid_d = 1'b1;
                    out_wid_d   = dec_wid;
                    out_rs1_d   = p_rs1;
                    out_rs2_d   = p_rs2;
                    out_rs3_d   = p_rs3;
                    out_rd_d    = p_rd;
                    wnd_err_d   = call_err || ret_err;
                    if (is_call && !call_err) begin
                        ws_d[dec_wid].cwp = cur.cwp + BW'(1);
                        ws_d[dec_wid].res = cur.res + RW'(1);
                    end else if (is_ret && !ret_err) begin
                        ws_d[dec_wid].cwp = cur.cwp - BW'(1);
                        ws_d[dec_wid].res = cur.res - RW'(1);
                    end
                end
            end
            REQ: begin
                spill_valid = 1'b1;
                if (spill_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (spill_done) begin
                    if (xfer_fill_q) begin
                        ws_d[xfer_wid_q].res = ws_q[xfer_wid_q].res + RW'(1);
                        ws_d[xfer_wid_q].spl = ws_q[xfer_wid_q].spl - SW'(1);
                    end else begin
                        ws_d[xfer_wid_q].res = ws_q[xfer_wid_q].res - RW'(1);
                        ws_d[xfer_wid_q].spl = ws_q[xfer_wid_q].spl + SW'(1);
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nRST) begin
            state_q <= IDLE;
            for (int i = 0; i < NUM_WARPS; i++) begin
                ws_q[i] <= WARP_RST;
            end
            xfer_wid_q  <= '0;
            xfer_blk_q  <= '0;
            xfer_fill_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_wid_q   <= '0;
            out_rs1_q   <= '0;
            out_rs2_q   <= '0;
            out_rs3_q   <= '0;
            out_rd_q    <= '0;
            wnd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ws_q        <= ws_d;
            xfer_wid_q  <= xfer_wid_d;
            xfer_blk_q  <= xfer_blk_d;
            xfer_fill_q <= xfer_fill_d;
            out_valid_q <= out_valid_d;
            out_wid_q   <= out_wid_d;
            out_rs1_q   <= out_rs1_d;
            out_rs2_q   <= out_rs2_d;
            out_rs3_q   <= out_rs3_d;
            out_rd_q    <= out_rd_d;
            wnd_err_q   <= wnd_err_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_wid    = out_wid_q;
    assign out_rs1    = out_rs1_q;
    assign out_rs2    = out_rs2_q;
    assign out_rs3    = out_rs3_q;
    assign out_rd     = out_rd_q;
    assign wnd_err    = wnd_err_q;
    assign spill_wid  = xfer_wid_q;
    assign spill_blk  = xfer_blk_q;
    assign spill_fill = xfer_fill_q;

endmodule

// File: tb/tb_vx_reg_wnd_mgr.sv
// Directed bench for vx_reg_wnd_mgr: window-rule model, per-cycle output compare, scripted memory side.
module tb_vx_reg_wnd_mgr;
    import vx_wnd_pkg::*;

    logic                 clk;
    logic                 nRST;
    logic [NUM_WARPS-1:0] wnd_en;
    logic                 dec_valid, dec_ready;
    logic [WID_W-1:0]     dec_wid;
    logic [AW-1:0]        dec_rs1, dec_rs2, dec_rs3, dec_rd;
    logic                 dec_call, dec_ret;
    logic                 out_valid;
    logic [WID_W-1:0]     out_wid;
    logic [PW-1:0]        out_rs1, out_rs2, out_rs3, out_rd;
    logic                 wnd_err;
    logic                 spill_valid, spill_ready;
    logic [WID_W-1:0]     spill_wid;
    logic [BW-1:0]        spill_blk;
    logic                 spill_fill, spill_done;

    vx_reg_wnd_mgr dut (
        .clk(clk), .nRST(nRST), .wnd_en(wnd_en),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_wid(dec_wid),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rs3(dec_rs3), .dec_rd(dec_rd),
        .dec_call(dec_call), .dec_ret(dec_ret),
        .out_valid(out_valid), .out_wid(out_wid),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rs3(out_rs3), .out_rd(out_rd),
        .wnd_err(wnd_err),
        .spill_valid(spill_valid), .spill_ready(spill_ready), .spill_wid(spill_wid),
        .spill_blk(spill_blk), .spill_fill(spill_fill), .spill_done(spill_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int wid;
        int blk;
        int fill;
    } xfer_t;

    int    vectors = 0;
    int    miscompares = 0;
    int    m_cwp [NUM_WARPS];
    int    m_res [NUM_WARPS];
    int    m_spl [NUM_WARPS];
    xfer_t exp_xq [$];
    int    lx_wid, lx_blk, lx_fill, lx_cnt;
    int    e_wid, e_err;
    int    e_rs [4];
    bit    exp_vld;
    int    exp_wid, exp_err;
    int    exp_rs [4];
    bit    cmp_on, suppress_done;
    int    hs_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_WARPS; i++) begin
            m_cwp[i] = 0;
            m_res[i] = 1;
            m_spl[i] = 0;
        end
        exp_xq.delete();
    endtask

    function automatic int map_reg(input int r, input int w);
        if (!wnd_en[w] || r < GLOBAL_REGS) return r;
        return GLOBAL_REGS + ((m_cwp[w] * WND_SIZE + (r - GLOBAL_REGS)) % (NUM_WND * WND_SIZE));
    endfunction

    task automatic push_xfer(input int w, input int blk, input int fill);
        xfer_t x;
        x.wid = w; x.blk = blk; x.fill = fill;
        exp_xq.push_back(x);
        lx_wid = w; lx_blk = blk; lx_fill = fill;
        lx_cnt++;
    endtask

    // Window rules applied as a whole instruction: any needed transfer first, then the call/return.
    task automatic model_apply(input int w, input int c, input int r,
                               input int a1, input int a2, input int a3, input int ad);
        e_wid   = w;
        e_rs[0] = map_reg(a1, w);
        e_rs[1] = map_reg(a2, w);
        e_rs[2] = map_reg(a3, w);
        e_rs[3] = map_reg(ad, w);
        e_err   = 0;
        if (wnd_en[w] && !(c != 0 && r != 0)) begin
            if (c != 0) begin
                if (m_res[w] == NUM_WND - 1 && m_spl[w] == MAX_SPILL) begin
                    e_err = 1;
                end else begin
                    if (m_res[w] == NUM_WND - 1) begin
                        push_xfer(w, (m_cwp[w] + 2) % NUM_WND, 0);
                        m_res[w]--;
                        m_spl[w]++;
                    end
                    m_cwp[w] = (m_cwp[w] + 1) % NUM_WND;
                    m_res[w]++;
                end
            end else if (r != 0) begin
                if (m_res[w] == 1 && m_spl[w] == 0) begin
                    e_err = 1;
                end else begin
                    if (m_res[w] == 1) begin
                        push_xfer(w, (m_cwp[w] + NUM_WND - 1) % NUM_WND, 1);
                        m_res[w]++;
                        m_spl[w]--;
                    end
                    m_cwp[w] = (m_cwp[w] + NUM_WND - 1) % NUM_WND;
                    m_res[w]--;
                end
            end
        end
    endtask

    task automatic issue(input int w, input int c, input int r,
                         input int a1, input int a2, input int a3, input int ad);
        int n;
        model_apply(w, c, r, a1, a2, a3, ad);
        dec_wid   = WID_W'(w);
        dec_call  = c[0];
        dec_ret   = r[0];
        dec_rs1   = AW'(a1);
        dec_rs2   = AW'(a2);
        dec_rs3   = AW'(a3);
        dec_rd    = AW'(ad);
        dec_valid = 1'b1;
        n = 0;
        #1;
        while (dec_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (dec_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: dec_ready stayed %b, required 1 within 300 cycles", dec_ready);
            dec_valid = 1'b0;
            @(negedge clk);
        end else begin
            @(posedge clk);
            #1;
            dec_valid = 1'b0;
            dec_call  = 1'b0;
            dec_ret   = 1'b0;
            exp_wid   = e_wid;
            exp_rs    = e_rs;
            exp_err   = e_err;
            exp_vld   = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        nRST      = 1'b0;
        dec_valid = 1'b0;
        dec_call  = 1'b0;
        dec_ret   = 1'b0;
        exp_vld   = 1'b0;
        repeat (3) @(negedge clk);
        nRST = 1'b1;
        model_reset();
    endtask

    // Output compare: every cycle, valid must match and a valid result must match the model.
    initial begin : compare
        forever begin
            @(negedge clk);
            if (cmp_on) begin
                chk("out_valid", 32'(out_valid), 32'(exp_vld));
                if (exp_vld) begin
                    chk("out_wid", 32'(out_wid), exp_wid);
                    chk("out_rs1", 32'(out_rs1), exp_rs[0]);
                    chk("out_rs2", 32'(out_rs2), exp_rs[1]);
                    chk("out_rs3", 32'(out_rs3), exp_rs[2]);
                    chk("out_rd", 32'(out_rd), exp_rs[3]);
                    chk("wnd_err", 32'(wnd_err), exp_err);
                end else begin
                    chk("wnd_err_idle", 32'(wnd_err), 0);
                end
                exp_vld = 1'b0;
            end
        end
    end

    initial begin : mem_side
        xfer_t x;
        spill_ready = 1'b0;
        spill_done  = 1'b0;
        forever begin
            @(negedge clk);
            if (spill_valid === 1'b1) begin
                repeat (hs_cnt % 3) begin
                    @(negedge clk);
                    chk("spill_valid_held", 32'(spill_valid), 1);
                end
                if (exp_xq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spill_unexpected: got request wid=%0d blk=%0d fill=%0d, required none",
                             spill_wid, spill_blk, spill_fill);
                end else begin
                    x = exp_xq.pop_front();
                    chk("spill_wid", 32'(spill_wid), x.wid);
                    chk("spill_blk", 32'(spill_blk), x.blk);
                    chk("spill_fill", 32'(spill_fill), x.fill);
                end
                spill_ready = 1'b1;
                @(negedge clk);
                spill_ready = 1'b0;
                hs_cnt++;
                if (!suppress_done) begin
                    repeat (hs_cnt % 2) @(negedge clk);
                    spill_done = 1'b1;
                    @(negedge clk);
                    spill_done = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : main
        int h0, n;
        wnd_en = '1; dec_wid = '0;
        dec_rs1 = '0; dec_rs2 = '0; dec_rs3 = '0; dec_rd = '0;
        cmp_on = 1'b0; suppress_done = 1'b0; exp_vld = 1'b0;
        hs_cnt = 0; lx_cnt = 0; lx_wid = -1; lx_blk = -1; lx_fill = -1;
        do_reset();
        cmp_on = 1'b1;

        chk("rst_dec_ready", 32'(dec_ready), 1);
        chk("rst_spill_valid", 32'(spill_valid), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_rs1", 32'(out_rs1), 0);
        chk("rst_out_rd", 32'(out_rd), 0);
        chk("rst_spill_blk", 32'(spill_blk), 0);

        // Plain remap straight out of reset
        issue(0, 0, 0, 5, 16, 31, 0);
        chk("s1_rs1", e_rs[0], 5);
        chk("s1_rs2", e_rs[1], 16);
        chk("s1_rs3", e_rs[2], 31);

        // Call maps with pre-call cwp; following request sees cwp=1
        issue(0, 1, 0, 20, 0, 0, 0);
        chk("s2_call_rs1", e_rs[0], 20);
        issue(0, 0, 0, 16, 31, 0, 0);
        chk("s2_rs1", e_rs[0], 24);
        chk("s2_rs2", e_rs[1], 39);

        // Three calls from reset: third spills block 0
        do_reset();
        repeat (3) issue(0, 1, 0, 0, 0, 0, 0);
        chk("s3_spill_wid", lx_wid, 0);
        chk("s3_spill_blk", lx_blk, 0);
        chk("s3_spill_fill", lx_fill, 0);
        chk("s3_cwp", m_cwp[0], 3);
        chk("s3_res", m_res[0], 3);
        chk("s3_spl", m_spl[0], 1);
        issue(0, 0, 0, 16, 31, 0, 0);
        chk("s3_rs1", e_rs[0], 40);
        chk("s3_rs2_wrap", e_rs[1], 23);

        // Returns down to underflow
        repeat (2) issue(0, 0, 1, 0, 0, 0, 0);
        chk("s4_cwp", m_cwp[0], 1);
        chk("s4_res", m_res[0], 1);
        issue(0, 0, 1, 0, 0, 0, 0);
        chk("s4_fill_blk", lx_blk, 0);
        chk("s4_fill_dir", lx_fill, 1);
        chk("s4_fill_cwp", m_cwp[0], 0);
        chk("s4_fill_spl", m_spl[0], 0);
        issue(0, 0, 1, 0, 0, 0, 0);
        chk("s4_underflow_err", e_err, 1);
        chk("s4_underflow_cwp", m_cwp[0], 0);
        chk("s4_underflow_res", m_res[0], 1);

        // Call and return together behave as neither
        issue(0, 1, 1, 16, 0, 0, 0);
        chk("both_rs1", e_rs[0], 16);
        chk("both_cwp", m_cwp[0], 0);

        // Disabled warp 1 interleaved with windowed warp 0
        wnd_en = 4'b1101;
        issue(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            issue(1, 1, 0, 30, 16, 2, 17);
            chk("s5_rs1", e_rs[0], 30);
            chk("s5_rd", e_rs[3], 17);
        end
        issue(1, 0, 1, 30, 0, 0, 0);
        chk("s5_w1_cwp", m_cwp[1], 0);
        chk("s5_no_xfer", lx_cnt, 2);
        issue(0, 0, 0, 16, 0, 0, 0);
        chk("s5_w0_rs1", e_rs[0], 24);
        wnd_en = '1;

        // Warp 2 spills until MAX_SPILL, then overflows
        repeat (2 + MAX_SPILL) issue(2, 1, 0, 0, 0, 0, 0);
        chk("ovf_spl", m_spl[2], 15);
        chk("ovf_res", m_res[2], 3);
        chk("ovf_xfers", lx_cnt, 17);
        issue(2, 1, 0, 20, 0, 0, 0);
        chk("ovf_err", e_err, 1);
        chk("ovf_rs1", e_rs[0], 28);

        // Reset while waiting for spill_done
        repeat (2) issue(3, 1, 0, 0, 0, 0, 0);
        suppress_done = 1'b1;
        h0 = hs_cnt;
        model_apply(3, 1, 0, 0, 0, 0, 0);
        chk("s6_spill_blk", lx_blk, 0);
        dec_wid = 2'd3; dec_call = 1'b1; dec_ret = 1'b0;
        dec_rs1 = '0; dec_rs2 = '0; dec_rs3 = '0; dec_rd = '0;
        dec_valid = 1'b1;
        n = 0;
        while (hs_cnt == h0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("s6_handshake_seen", 32'(hs_cnt != h0), 1);
        @(negedge clk);
        chk("s6_wait_dec_ready", 32'(dec_ready), 0);
        nRST = 1'b0;
        dec_valid = 1'b0;
        dec_call = 1'b0;
        @(negedge clk);
        chk("s6_rst_spill_valid", 32'(spill_valid), 0);
        chk("s6_rst_dec_ready", 32'(dec_ready), 1);
        nRST = 1'b1;
        suppress_done = 1'b0;
        model_reset();
        issue(0, 0, 0, 16, 0, 0, 0);
        chk("s6_rs1", e_rs[0], 16);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
